gdiv16: RTL and testbench

//  Galois-field divider, the inverse operation of the GF(2^16) multiplier in the

---
 rtl/gdiv16.sv | 144 ++++++++++++++
 tb/tb_gdiv16.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gdiv16.sv
// gdiv16 - Galois-field divider over GF(2^DWIDTH).
//
// Computes q = a / b = a * b^-1, where the field polynomial is x^DWIDTH + m.
// The inverse b^-1 is obtained as b^(2^DWIDTH-2) (Fermat) using iterative
// square-and-multiply, one step per clock. Only one operation is in flight;
// the caller starts it with req and collects the result on the rdy pulse.
//
// Ports:
//   clk       in   1       clock, all state updates on the rising edge
//   rst_n     in   1       asynchronous active-low reset
//   req       in   1       start pulse, only sampled while busy is low
//   a         in   DWIDTH  dividend, captured when req is accepted
//   b         in   DWIDTH  divisor, captured when req is accepted
//   m         in   DWIDTH  reduction polynomial low terms, captured on accept
//   q         out  DWIDTH  quotient, valid with rdy and held until next accept
//   rdy       out  1       one-cycle completion pulse
//   busy      out  1       high while an operation is being computed
//   div_zero  out  1       set with rdy when the captured divisor was zero
module gdiv16 #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic [DWIDTH-1:0] m,
  output logic [DWIDTH-1:0] q,
  output logic              rdy,
  output logic              busy,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(DWIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] a_q;
  logic [DWIDTH-1:0] b_q;
  logic [DWIDTH-1:0] m_q;
  logic [DWIDTH-1:0] sq_q;
  logic [DWIDTH-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DWIDTH-1:0] quot_q;
  logic              rdy_q;
  logic              busy_q;
  logic              div_zero_q;

  logic [DWIDTH-1:0] sq_d;
  logic [DWIDTH-1:0] acc_d;
  logic [DWIDTH-1:0] quot_d;

  // Shift-and-add multiply, MSB of y first. Whenever the running product
  // would overflow past bit DWIDTH-1, the implicit x^DWIDTH is folded back
  // in by xoring the low-term polynomial.
  function automatic logic [DWIDTH-1:0] gfmul(
    input logic [DWIDTH-1:0] x,
    input logic [DWIDTH-1:0] y,
    input logic [DWIDTH-1:0] mp
  );
    logic [DWIDTH-1:0] r;
    r = '0;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      r = {r[DWIDTH-2:0], 1'b0} ^ (r[DWIDTH-1] ? mp : '0);
      if (y[i]) begin
        r = r ^ x;
      end
    end
    return r;
  endfunction

  // sq walks through b^2, b^4, ... b^(2^(DWIDTH-1)); acc gathers their product,
  // which after DWIDTH-1 steps is b^(2^DWIDTH - 2) = b^-1.
  always_comb begin
    sq_d   = gfmul(sq_q, sq_q, m_q);
    acc_d  = gfmul(acc_q, sq_d, m_q);
    quot_d = gfmul(acc_q, a_q, m_q);
  end

  // Control and datapath state. rdy defaults low so it only pulses for the
  // single cycle following FIN; a request arriving in that cycle is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      sq_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            a_q     <= a;
            b_q     <= b;
            m_q     <= m;
            sq_q    <= b;
            acc_q   <= DWIDTH'(1);
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sq_q  <= sq_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          // A zero divisor has no inverse; report it and force q to zero.
          quot_q     <= (b_q == '0) ? '0 : quot_d;
          div_zero_q <= (b_q == '0);
          rdy_q      <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign q        = quot_q;
  assign rdy      = rdy_q;
  assign busy     = busy_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_gdiv16.sv
// tb_gdiv16 - scoreboard bench for the GF(2^16) divider.
//
// Expected quotients come from polynomial arithmetic: a full carry-less
// product reduced by long division, and the divisor inverse found with the
// extended Euclidean algorithm over GF(2)[x]. Stimulus pushes expectations
// into a queue; a monitor pops and compares on every rdy pulse.
module tb_gdiv16;

  localparam logic [15:0] POLY = 16'h100B;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] m;
  logic [15:0] q;
  logic        rdy;
  logic        busy;
  logic        div_zero;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] m;
    logic [15:0] q;
    logic        dz;
  } exp_t;

  exp_t expQ[$];

  int errCount = 0;
  int checkCount = 0;
  int cycleNum = 0;
  int lastRdyCycle = 0;
  logic prevRdy = 1'b0;

  gdiv16 #(.DWIDTH(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .a(a),
    .b(b),
    .m(m),
    .q(q),
    .rdy(rdy),
    .busy(busy),
    .div_zero(div_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency and spacing measurements
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Carry-less product, low 32 bits
  function automatic logic [31:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (y[i]) r = r ^ (x << i);
    end
    return r;
  endfunction

  function automatic int degOf(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  // Remainder modulo x^16 + mv
  function automatic logic [15:0] polyMod(input logic [31:0] x, input logic [15:0] mv);
    logic [31:0] f;
    logic [31:0] r;
    f = {15'b0, 1'b1, mv};
    r = x;
    for (int i = 31; i >= 16; i--) begin
      if (r[i]) r = r ^ (f << (i - 16));
    end
    return r[15:0];
  endfunction

  function automatic logic [15:0] gfMulRef(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] mv);
    return polyMod(clmul({16'b0, x}, {16'b0, y}), mv);
  endfunction

  // Extended Euclid: tracks t such that t*b == r (mod f) until r reaches 1
  function automatic logic [15:0] gfInv(input logic [15:0] bv, input logic [15:0] mv);
    logic [31:0] r0, r1, t0, t1, qq, rr, tmp;
    int sh;
    r0 = {15'b0, 1'b1, mv};
    r1 = {16'b0, bv};
    t0 = '0;
    t1 = 32'd1;
    while (r1 != 0) begin
      qq = '0;
      rr = r0;
      while (rr != 0 && degOf(rr) >= degOf(r1)) begin
        sh = degOf(rr) - degOf(r1);
        qq = qq ^ (32'd1 << sh);
        rr = rr ^ (r1 << sh);
      end
      tmp = t0 ^ clmul(qq, t1);
      t0 = t1;
      t1 = tmp;
      r0 = r1;
      r1 = rr;
    end
    return polyMod(t0, mv);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every rdy pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rdy) begin
      checkOutput("rdyPulseWidth", {31'b0, prevRdy}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("spuriousRdy", {31'b0, rdy}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("quotient", {16'b0, q}, {16'b0, e.q});
        checkOutput("divZero", {31'b0, div_zero}, {31'b0, e.dz});
        if (e.b != 0) checkOutput("qTimesB", {16'b0, gfMulRef(q, e.b, e.m)}, {16'b0, e.a});
      end
    end
    prevRdy = rdy;
  end

  // Issue one division, wait for its rdy, check latency and optional spacing
  // from the previous rdy. With noise set, extra req pulses are sent while busy.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input bit checkGap, input bit noise);
    exp_t e;
    int cycles;
    int startCyc;
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("idleBeforeReq", {31'b0, busy}, 32'd0);
    a = av;
    b = bv;
    m = POLY;
    req = 1'b1;
    @(posedge clk);
    startCyc = cycleNum;
    e.a = av;
    e.b = bv;
    e.m = POLY;
    e.dz = (bv == 0);
    e.q = (bv == 0) ? 16'h0 : gfMulRef(av, gfInv(bv, POLY), POLY);
    expQ.push_back(e);
    #1;
    req = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    m = 16'($urandom);
    checkOutput("busyAfterAccept", {31'b0, busy}, 32'd1);
    cycles = 0;
    while (!rdy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (noise) begin
        req = (cycles < 14) && (cycles % 3 == 1);
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    req = 1'b0;
    checkOutput("latency", 32'(cycles), 32'd16);
    if (checkGap) checkOutput("backToBackGap", 32'(cycleNum - lastRdyCycle), 32'd17);
    lastRdyCycle = cycleNum;
    if (startCyc < 0) $display("[TB] unreachable");
  endtask

  // Global time limit so the bench always ends
  initial begin
    #3000000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    req = 1'b0;
    a = '0;
    b = '0;
    m = POLY;
    #12;
    checkOutput("resetQ", {16'b0, q}, 32'd0);
    checkOutput("resetRdy", {31'b0, rdy}, 32'd0);
    checkOutput("resetBusy", {31'b0, busy}, 32'd0);
    checkOutput("resetDivZero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    checkOutput("oneOverOne", {16'b0, q}, 32'h0001);
    applyStimulus(16'h0001, 16'h0002, 1'b1, 1'b0);
    checkOutput("inverseOfX", {16'b0, q}, 32'h8805);
    applyStimulus(16'h0002, 16'h0002, 1'b1, 1'b0);
    checkOutput("xOverX", {16'b0, q}, 32'h0001);
    applyStimulus(16'h1234, 16'h0000, 1'b1, 1'b0);
    checkOutput("divByZeroQ", {16'b0, q}, 32'h0000);
    checkOutput("divByZeroFlag", {31'b0, div_zero}, 32'd1);
    applyStimulus(16'h0000, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("zeroDividendQ", {16'b0, q}, 32'h0000);
    checkOutput("zeroDividendFlag", {31'b0, div_zero}, 32'd0);

    // Requests while busy must be ignored
    applyStimulus(16'hA5A5, 16'h3C3C, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("noQueuedReq", {31'b0, busy}, 32'd0);

    // Reset in the middle of an operation
    a = 16'h4321;
    b = 16'h0777;
    m = POLY;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("busyMidRun", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abortQ", {16'b0, q}, 32'd0);
    checkOutput("abortRdy", {31'b0, rdy}, 32'd0);
    checkOutput("abortBusy", {31'b0, busy}, 32'd0);
    checkOutput("abortDivZero", {31'b0, div_zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    applyStimulus(16'h4321, 16'h0777, 1'b0, 1'b0);

    // Random back-to-back divisions
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(16'($urandom), 16'($urandom_range(1, 65535)), 1'b1, 1'b0);
    end

    repeat (20) @(posedge clk);
    checkOutput("pendingAtEnd", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
